// File: rtl/mul_seq_booth_param.sv
// Sequential radix-2 Booth multiplier with signed/unsigned and accumulate modes.
// It takes x+1 Booth steps per operation and uses a start/busy/ready handshake.
// The result register mul is written on the edge that leaves DONE.
// It then holds that value until the next completion.
module mul_seq_booth_param #(
    parameter int x = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic           accumulate,
    input  logic [x-1:0]   OpA,
    input  logic [x-1:0]   OpB,
    output logic           busy,
    output logic           ready,
    output logic [2*x-1:0] mul
);

    // Wide enough to hold the step count x+1.
    localparam int cntW = $clog2(x + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT           state;
    logic [x+1:0]    mcand;   // extended multiplicand, two guard bits
    logic [x+1:0]    upper;   // upper half of the partial product
    logic [x:0]      mplier;  // Booth multiplier register Q
    logic            qm1;     // appended bit q(-1)
    logic [cntW-1:0] count;
    logic            accReg;

    logic [x+1:0]    sum;
    logic [2*x-1:0]  product;

    // Booth recode of {q0, q(-1)}: add, subtract or pass the upper half.
    always_comb begin
        // NOTE: assign a default first so every path writes sum and no latch is inferred.
        sum = upper;
        case ({mplier[0], qm1})
            2'b01:   sum = upper + mcand;
            2'b10:   sum = upper - mcand;
            default: sum = upper;
        endcase
    end

    // The low 2x bits of {upper, Q} form the product.
    // x >= 2 guarantees the upper slice below exists.
    assign product = {upper[x-2:0], mplier};

    // Control FSM and datapath in one block, with registered busy/ready.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments.
        // Every read in this block therefore sees the pre-edge value.
        // The DONE-cycle mul write and a back-to-back capture can share one edge.
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ready  <= 1'b0;
            mul    <= '0;
            mcand  <= '0;
            upper  <= '0;
            mplier <= '0;
            qm1    <= 1'b0;
            count  <= '0;
            accReg <= 1'b0;
        end else begin
            if (state == DONE) begin
                mul <= accReg ? (mul + product) : product;
            end

            case (state)
                RUN: begin
                    // Arithmetic shift right of {sum, Q, q(-1)} by one bit.
                    upper  <= {sum[x+1], sum[x+1:1]};
                    mplier <= {sum[0], mplier[x:1]};
                    qm1    <= mplier[0];
                    count  <= count - cntW'(1);
                    if (count == cntW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    ready <= 1'b0;
                    if (start) begin
                        mcand  <= {{2{signed_mode & OpA[x-1]}}, OpA};
                        mplier <= {signed_mode & OpB[x-1], OpB};
                        upper  <= '0;
                        qm1    <= 1'b0;
                        count  <= cntW'(x + 1);
                        accReg <= accumulate;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_booth_param.sv
// Directed bench for mul_seq_booth_param with an 8-bit and a 16-bit instance.
// Expected results are queued when an operation is issued.
// Each one is popped when the DUT's mul update becomes visible.
module tb_mul_seq_booth_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, sgn8, acc8;
    logic [7:0]  opA8, opB8;
    logic        busy8, ready8;
    logic [15:0] mul8;
    logic        start16, sgn16, acc16;
    logic [15:0] opA16, opB16;
    logic        busy16, ready16;
    logic [31:0] mul16;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    mul_seq_booth_param #(.x(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sgn8),
        .accumulate(acc8), .OpA(opA8), .OpB(opB8),
        .busy(busy8), .ready(ready8), .mul(mul8)
    );

    mul_seq_booth_param #(.x(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sgn16),
        .accumulate(acc16), .OpA(opA16), .OpB(opB16),
        .busy(busy16), .ready(ready16), .mul(mul16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic busyOf(input bit wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic logic readyOf(input bit wide);
        return wide ? ready16 : ready8;
    endfunction

    function automatic logic [31:0] mulOf(input bit wide);
        return wide ? mul16 : {16'h0, mul8};
    endfunction

    // Called at a negedge: drive start for the coming edge and queue the expected mul.
    task automatic drive(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input bit sgn, input bit acc, input logic [31:0] expv);
        if (wide) begin
            opA16 = a; opB16 = b; sgn16 = sgn; acc16 = acc; start16 = 1'b1;
        end else begin
            opA8 = a[7:0]; opB8 = b[7:0]; sgn8 = sgn; acc8 = acc; start8 = 1'b1;
        end
        expQ.push_back(expv);
    endtask

    task automatic checkMul(input bit wide, input string tag);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            check(tag, mulOf(wide), expQ.pop_front());
        end
    endtask

    // Waits out the busy phase of an operation started at the next edge.
    // It ends at the DONE-cycle negedge.
    // With popFirst set, it first checks mul written by the previous DONE edge.
    task automatic waitReady(input bit wide, input int expBusy, input bit popFirst,
                             input string tag);
        int cycles = 0;
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        if (popFirst) checkMul(wide, {tag, "_prev_mul"});
        while (busyOf(wide) === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cycles, expBusy);
        check({tag, "_ready"}, {31'h0, readyOf(wide)}, 32'h1);
        check({tag, "_busy_low"}, {31'h0, busyOf(wide)}, 32'h0);
    endtask

    // One edge past DONE: ready has dropped and mul carries the result.
    task automatic finishOp(input bit wide, input string tag);
        @(negedge clk);
        check({tag, "_ready_drop"}, {31'h0, readyOf(wide)}, 32'h0);
        checkMul(wide, {tag, "_mul"});
    endtask

    initial begin
        int readyCount;
        reset = 1'b1;
        start8 = 1'b0; sgn8 = 1'b0; acc8 = 1'b0; opA8 = '0; opB8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; acc16 = 1'b0; opA16 = '0; opB16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_busy", {31'h0, busy8}, 32'h0);
        check("rst_ready", {31'h0, ready8}, 32'h0);
        check("rst_mul", {16'h0, mul8}, 32'h0);

        // Unsigned full-scale square.
        drive(0, 16'd255, 16'd255, 0, 0, 32'h0000FE01);
        waitReady(0, 9, 0, "u255");
        finishOp(0, "u255");
        readyCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready8) readyCount++;
        end
        check("u255_single_ready", readyCount, 0);

        // Signed corner cases.
        drive(0, 16'h0080, 16'h0080, 1, 0, 32'h00004000);
        waitReady(0, 9, 0, "s_m128sq");
        finishOp(0, "s_m128sq");
        drive(0, 16'h00FF, 16'h007F, 1, 0, 32'h0000FF81);
        waitReady(0, 9, 0, "s_m1x127");
        finishOp(0, "s_m1x127");

        // Back-to-back: the second start lands in the DONE cycle and accumulates.
        @(negedge clk);
        drive(0, 16'd3, 16'd4, 0, 0, 32'h0000000C);
        waitReady(0, 9, 0, "b2b_first");
        drive(0, 16'd5, 16'd6, 0, 1, 32'h0000002A);
        waitReady(0, 9, 1, "b2b_second");
        finishOp(0, "b2b_second");

        // A start raised during RUN must be ignored.
        @(negedge clk);
        drive(0, 16'd7, 16'd9, 0, 0, 32'd63);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        opA8 = 8'd1; opB8 = 8'd1; start8 = 1'b1;
        waitReady(0, 5, 0, "ign_start");
        finishOp(0, "ign_start");
        readyCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready8 || busy8) readyCount++;
        end
        check("ign_no_restart", readyCount, 0);

        // Reset three cycles into RUN aborts with no ready pulse.
        drive(0, 16'd11, 16'd13, 0, 0, 32'h0);
        void'(expQ.pop_back());
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'h0, busy8}, 32'h0);
        check("abort_mul", {16'h0, mul8}, 32'h0);
        readyCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready8) readyCount++;
        end
        check("abort_no_ready", readyCount, 0);

        // Accumulate wraps modulo 2^16.
        drive(0, 16'd255, 16'd255, 0, 1, 32'h0000FE01);
        waitReady(0, 9, 0, "acc1");
        finishOp(0, "acc1");
        drive(0, 16'd255, 16'd255, 0, 1, 32'h0000FC02);
        waitReady(0, 9, 0, "acc2");
        finishOp(0, "acc2");

        // Wide instance.
        drive(1, 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001);
        waitReady(1, 17, 0, "w_uffff");
        finishOp(1, "w_uffff");
        drive(1, 16'h8000, 16'h7FFF, 1, 0, 32'hC0008000);
        waitReady(1, 17, 0, "w_smin");
        finishOp(1, "w_smin");

        check("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_booth_param.md
Name: mul_seq_booth_param

Overview:
- Parametrised sequential radix-2 Booth multiplier; successor to the current unsigned shift-add multiplier datapath/control pair.
- Datapath and control are merged in one block.
- Adds a per-operation signed/unsigned mode and an accumulate (MAC) mode.
- Keeps the start/busy/ready handshake, so existing testbench drivers reuse unchanged.

Parameters:
- x, 8, operand width in bits; x >= 2; product width is 2*x.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- accumulate  input  1  1 = add product to current mul, 0 = overwrite mul; captured with start.
- OpA  input  x  multiplicand; captured with start.
- OpB  input  x  multiplier; captured with start.
- busy  output  1  operation in progress.
- ready  output  1  one-cycle pulse: mul holds a new valid result.
- mul  output  2*x  result register; holds its value until the next completion.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - busy=0, ready=0, mul=0.
  - Step counter, internal operand registers and partial product cleared; FSM -> IDLE.
  - Reset has priority over every other input, including mid-operation: the operation is aborted, no ready pulse, mul=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: capture OpA, OpB, signed_mode and accumulate.
  - Operands are extended to x+1 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Clear the partial-product register, load the Booth multiplier register with the extended OpB plus appended bit q(-1)=0, set counter=x+1, go to RUN.
- RUN:
  - busy=1.
  - Each cycle inspects the pair {q0, q(-1)}:
    - 01: add extended A to the upper half.
    - 10: subtract extended A from the upper half.
    - 00 / 11: no operation.
  - Then arithmetic-shift-right the {upper, Q, q(-1)} register by 1 and decrement the counter.
  - After x+1 steps (counter reaches 0) go to DONE.
  - RUN occupies exactly x+1 cycles.
- DONE (one cycle):
  - busy=0, ready=1.
  - The edge leaving DONE writes mul = P[2x-1:0] (accumulate=0) or mul = mul + P[2x-1:0] modulo 2^(2x) (accumulate=1, wraps silently).
  - Next state is IDLE.
  - A start asserted during DONE is accepted exactly as in IDLE (back-to-back operation).
  - A back-to-back operation with accumulate=1 sees the freshly written mul.
- Latency: start sampled at edge E0 -> busy=1 from E0 through E0+(x+1) -> ready=1 during the cycle after edge E0+(x+1) -> mul valid at edge E0+x+2.
- start=1 while in RUN is ignored. There is no queueing and captured operands are not disturbed.
- OpA, OpB and mode inputs may change freely after the capture edge without effect.
- Width rules:
  - Internal add/sub runs on x+1 bits (x+2 if needed to avoid overflow of the upper half).
  - The extended product fits 2x bits for both modes: unsigned max (2^x-1)^2, signed min/max magnitude 2^(2x-2). Only the low 2x bits are kept.
  - In signed mode, mul is interpreted as two's complement.
- busy and ready are never both 1.
- ready is exactly one cycle wide per completed operation.

Test Plan:
- x=8, unsigned, OpA=255, OpB=255, accumulate=0 -> busy high 9 cycles, ready pulses once, mul=16'hFE01.
- x=8, signed, OpA=-128 (8'h80), OpB=-128 -> mul=16'h4000; then OpA=-1, OpB=127 -> mul=16'hFF81.
- x=8, unsigned 3*4 (acc=0) then, started during the DONE cycle, 5*6 (acc=1) -> first mul=16'h000C, second mul=16'h002A; no idle cycle between operations.
- x=8, unsigned 255*255 with acc=1 repeated twice from mul=0 -> 16'hFE01 then 16'hFC02 (wraps mod 2^16).
- Start 7*9 and, 4 cycles into RUN, assert start with OpA=1, OpB=1 -> second start ignored, mul=63, single ready pulse; in a separate run, assert reset 3 cycles into RUN -> busy=0, mul=0, no ready pulse.
- x=16, unsigned 16'hFFFF*16'hFFFF -> mul=32'hFFFE0001 after 17 RUN cycles; signed 16'h8000*16'h7FFF -> mul=32'hC0008000.
